cluster_clock_divider: RTL and testbench
========================================

# cluster_clock_divider

Programmable integer clock divider that sits directly upstream of the cluster clock buffer and produces the clock it distributes. It divides `clk_i` by a runtime ratio, and ratio changes are applied only at period boundaries, so the output never glitches. Enable gating is also applied only at period boundaries, so the output stops cleanly low. A static test-mode bypass forwards the undivided clock for scan/ATPG.

## Interface
Parameters:
- `DIV_WIDTH`, default 8: width of the ratio field; legal ratios are 2..2^DIV_WIDTH-1.
- `DEFAULT_DIV`, default 2: ratio loaded at reset; must be 2..2^DIV_WIDTH-1.

Ports:
- `clk_i` in 1: input clock; single clock domain.
- `rst_i` in 1: asynchronous, active-high reset.
- `test_mode_i` in 1: quasi-static; when 1, `clk_o = clk_i` combinationally.
- `en_i` in 1: divider run enable; sampled only at period boundaries.
- `div_i` in DIV_WIDTH: requested ratio.
- `div_valid_i` in 1: ratio request valid.
- `div_ready_o` out 1: ratio request accepted when `div_valid_i & div_ready_o` at a `clk_i` posedge.
- `clk_o` out 1: divided clock, fed to the cluster clock buffer.

## Operation
State:
- `ratio_q` (DIV_WIDTH): active ratio N.
- `cnt_q` (DIV_WIDTH): phase counter, 0..N-1.
- `clk_q`: registered divided clock.
- `pend_q` / `pend_div_q`: pending ratio request.

Rules:
- Reset, asynchronous: `ratio_q = DEFAULT_DIV`, `cnt_q = DEFAULT_DIV-1`, `clk_q = 0`, `pend_q = 0`, `div_ready_o = 1`.
- `clk_o = test_mode_i ? clk_i : clk_q`.
- Boundary: `cnt_q == ratio_q-1`.
- Half-period: `H = (N+1)>>1`, computed at DIV_WIDTH+1 bits so N = 2^W-1 does not overflow.
- Running: each posedge sets `cnt_q` to `cnt_q+1`, or to 0 at the boundary. `clk_q` takes `(next cnt < H)`, giving H cycles high and N-H cycles low. Even N gives 50% duty; odd N has the extra cycle high.
- Boundary with `en_i = 0`: the divider stops.
  - `cnt_q` holds at N-1 and `clk_q` stays 0; the low phase is last, so stopping cannot truncate a high pulse.
  - It restarts at the first posedge where it is at the boundary with `en_i = 1`.
  - `en_i` changes mid-period are ignored until the boundary.
- Ratio request:
  - `div_ready_o = !pend_q`.
  - On handshake, `pend_div_q` takes `max(div_i, 2)`; values 0 and 1 clamp to 2.
  - Requests offered while `pend_q = 1` wait; this is normal valid/ready backpressure, and `div_valid_i` must hold `div_i` stable until accepted.
- Apply: at the first posedge after acceptance where the counter is at the boundary, `ratio_q` takes `pend_div_q` and `pend_q` clears.
  - If running: `cnt_q` goes to 0 and `clk_q` goes to 1 (new period at the new ratio).
  - If stopped: `cnt_q` goes to new N-1 and `clk_q` stays 0.
- Simultaneous handshake and apply: not possible, because ready is low while pending.
- Reset mid-period: `clk_o` drops low immediately (unless in test mode), and any pending request is discarded.

## Timing
- Registered output: `clk_q` changes one `clk_i` posedge after the state that decides it; there is no combinational path from `en_i`/`div_*` to `clk_o`.
- After reset release with `en_i = 1`: `clk_o` rises at the first posedge. For N = 2: high 1 cycle, low 1 cycle, repeating.
- Ratio change latency: the new period starts at the first boundary after acceptance.
  - Accepting with the counter at the boundary: applies on the next posedge (1 cycle).
  - Accepting on the posedge where the counter leaves the boundary (the one that starts a new period): applies at the end of that period, N_old cycles later.
- `div_ready_o` returns to 1 the cycle after apply.
- Period of `clk_o` = exactly N `clk_i` cycles. Every high pulse is H cycles wide and every low pulse is N-H wide; no runt pulses.

## Test plan
- Reset, `en_i=1`, DEFAULT_DIV=2 → `clk_o` toggles every cycle starting at the first posedge. `div_ready_o=1` throughout.
- Request `div_i=5` while running at N=2 → accepted in 1 cycle, `div_ready_o` low until the boundary. Next period: high 3 cycles, low 2; no pulse shorter than 1 cycle at the switch.
- `div_i=0`, then `div_i=1` → both apply as N=2. Then `div_i=255` (W=8) → high 128 cycles, low 127, with no H overflow.
- Drop `en_i` mid-high-phase at N=4 → current pulse completes as 2 high, 2 low, then `clk_o` stays 0. Raise `en_i` → `clk_o` rises the next posedge.
- Hold `div_valid_i` with a second value while one is pending → stalled until apply, then accepted; both ratios appear in order.
- Assert `rst_i` mid-high-phase → `clk_o` = 0 without waiting for a clock, and pending is cleared. With `test_mode_i=1`, `clk_o` follows `clk_i` regardless of reset and enable.

Source files
------------

// File: rtl/cluster_clock_divider.sv
// Glitch-free programmable integer divider feeding the cluster clock buffer.
// Ratio changes and enable gating only take effect at period boundaries.
module cluster_clock_divider #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 clk_o
);

  localparam logic [DIV_WIDTH-1:0] RESET_RATIO = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_RATIO   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] RATIO_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   HALF_ONE    = (DIV_WIDTH+1)'(1);

  logic [DIV_WIDTH-1:0] ratio_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] pend_div_q;
  logic                 clk_q;
  logic                 pend_q;

  logic                 at_boundary;
  logic                 accept;
  logic                 high_next;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] stop_ratio;
  logic [DIV_WIDTH:0]   half;

  // Half-period uses one extra bit so the largest ratio cannot wrap.
  assign half        = ({1'b0, ratio_q} + HALF_ONE) >> 1;
  assign cnt_inc     = cnt_q + RATIO_ONE;
  assign high_next   = ({1'b0, cnt_inc} < half);
  assign at_boundary = (cnt_q == (ratio_q - RATIO_ONE));
  assign accept      = div_valid_i & ~pend_q;
  assign div_clamped = (div_i < MIN_RATIO) ? MIN_RATIO : div_i;
  assign stop_ratio  = pend_q ? pend_div_q : ratio_q;

  assign div_ready_o = ~pend_q;
  assign clk_o       = test_mode_i ? clk_i : clk_q;

  // Low phase ends each period, so parking at the boundary never cuts a high pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ratio_q <= RESET_RATIO;
      cnt_q   <= RESET_RATIO - RATIO_ONE;
      clk_q   <= 1'b0;
    end else if (at_boundary) begin
      if (pend_q) begin
        ratio_q <= pend_div_q;
      end
      if (en_i) begin
        cnt_q <= '0;
        clk_q <= 1'b1;
      end else begin
        cnt_q <= stop_ratio - RATIO_ONE;
        clk_q <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_inc;
      clk_q <= high_next;
    end
  end

  // Accept and apply never coincide because ready is low while a request is pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      pend_div_q <= RESET_RATIO;
    end else if (accept) begin
      pend_q     <= 1'b1;
      pend_div_q <= div_clamped;
    end else if (pend_q && at_boundary) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cluster_clock_divider.sv
// Bench for cluster_clock_divider: directed steps plus random traffic checked
// against a period-level model built from remaining high/low cycle counts.
module tb_cluster_clock_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         test_mode;
  logic         en;
  logic [W-1:0] div;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;

  int vectors     = 0;
  int miscompares = 0;

  int m_n;
  int m_hi;
  int m_lo;
  bit m_out;
  int m_pend[$];
  int req_q[$];

  always #5 clk = ~clk;

  cluster_clock_divider #(
    .DIV_WIDTH  (W),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_mode_i(test_mode),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
    .clk_o      (clk_out)
  );

  task automatic modelReset();
    m_n   = 2;
    m_hi  = 0;
    m_lo  = 0;
    m_out = 1'b0;
    m_pend.delete();
  endtask

  // One clk_i posedge of the divider seen as whole periods of H high then N-H low.
  task automatic modelStep(input bit e, input bit v, input int d);
    bit ready_pre;
    int h;
    ready_pre = (m_pend.size() == 0);
    if (m_hi == 0 && m_lo == 0) begin
      if (m_pend.size() > 0) m_n = m_pend.pop_front();
      if (e) begin
        h     = (m_n + 1) / 2;
        m_out = 1'b1;
        m_hi  = h - 1;
        m_lo  = m_n - h;
      end else begin
        m_out = 1'b0;
      end
    end else if (m_hi > 0) begin
      m_out = 1'b1;
      m_hi  = m_hi - 1;
    end else begin
      m_out = 1'b0;
      m_lo  = m_lo - 1;
    end
    if (v && ready_pre) m_pend.push_back((d < 2) ? 2 : d);
  endtask

  task automatic checkOutput(input string tag);
    logic exp_clk;
    logic exp_rdy;
    exp_clk = test_mode ? clk : m_out;
    exp_rdy = (m_pend.size() == 0);
    vectors++;
    assert (clk_out === exp_clk) else begin
      miscompares++;
      $error("[TB] FAIL %s clk_o: got %b expected %b at %0t", tag, clk_out, exp_clk, $time);
    end
    vectors++;
    assert (div_ready === exp_rdy) else begin
      miscompares++;
      $error("[TB] FAIL %s div_ready_o: got %b expected %b at %0t", tag, div_ready, exp_rdy, $time);
    end
  endtask

  task automatic applyStimulus(input string tag);
    bit accepted;
    int d;
    d         = 0;
    div_valid = (req_q.size() > 0);
    if (div_valid) d = req_q[0];
    div = W'(d);
    @(posedge clk);
    accepted = div_valid && (m_pend.size() == 0);
    modelStep(en, div_valid, d);
    if (accepted) void'(req_q.pop_front());
    #1;
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(tag);
  endtask

  task automatic checkBound(input int k, input int budget, input string tag);
    vectors++;
    assert (k < budget) else begin
      miscompares++;
      $error("[TB] FAIL %s timeout: waited %0d cycles, limit %0d", tag, k, budget);
    end
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    int k;
    k = 0;
    while ((req_q.size() > 0 || m_pend.size() > 0) && k < budget) begin
      applyStimulus(tag);
      k++;
    end
    checkBound(k, budget, tag);
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    test_mode = 1'b0;
    en        = 1'b1;
    div_valid = 1'b0;
    div       = '0;
    modelReset();
    $display("[TB] starting cluster_clock_divider bench");

    #3;
    checkOutput("reset_state");
    @(negedge clk);
    rst = 1'b0;
    runCycles(8, "n2_run");

    req_q.push_back(5);
    runUntilIdle("req5", 20);
    runCycles(12, "n5_run");

    req_q.push_back(0);
    runUntilIdle("req0", 20);
    runCycles(4, "n0_run");
    req_q.push_back(1);
    runUntilIdle("req1", 20);
    runCycles(4, "n1_run");
    req_q.push_back(255);
    runUntilIdle("req255", 20);
    runCycles(520, "n255_run");

    req_q.push_back(4);
    runUntilIdle("req4", 600);
    k = 0;
    while (!(m_out && m_hi == 1) && k < 16) begin
      applyStimulus("find_high4");
      k++;
    end
    checkBound(k, 16, "find_high4");
    en = 1'b0;
    runCycles(8, "en_drop");
    en = 1'b1;
    runCycles(6, "en_raise");

    req_q.push_back(3);
    req_q.push_back(6);
    runUntilIdle("back_to_back", 40);
    runCycles(14, "n6_run");

    req_q.push_back(7);
    runUntilIdle("req7", 20);
    k = 0;
    while (!(m_out && m_hi == 3) && k < 20) begin
      applyStimulus("find_high7");
      k++;
    end
    checkBound(k, 20, "find_high7");
    req_q.push_back(9);
    applyStimulus("pend9");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    req_q.delete();
    div_valid = 1'b0;
    checkOutput("async_rst");
    @(posedge clk);
    #1;
    checkOutput("rst_hold");

    test_mode = 1'b1;
    en        = 1'b0;
    #1;
    checkOutput("bypass_rst_hi");
    @(negedge clk);
    #1;
    checkOutput("bypass_rst_lo");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("bypass_run_hi");
      @(negedge clk);
      #1;
      checkOutput("bypass_run_lo");
    end
    test_mode = 1'b0;
    en        = 1'b1;
    runCycles(6, "post_bypass");

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
      if (req_q.size() == 0 && $urandom_range(0, 9) == 0) begin
        req_q.push_back($urandom_range(0, 12));
        if ($urandom_range(0, 2) == 0) req_q.push_back($urandom_range(0, 12));
      end
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
